ysyx_24100005_wbu: RTL and testbench
====================================

// Module: ysyx_24100005_wbu
// PURPOSE
//  Writeback unit directly upstream of the GPR file (ysyx_24100005_RegisterFile).
//  - Accepts ALU results and load requests from EXU over a valid/ready handshake.
//  - Waits for the load data from memory, then extracts the byte lane and sign/zero-extends it.
//  - Drives rf_wen/rf_waddr/rf_wdata for exactly one cycle per committed instruction.
//  - Pulses wb_done on every commit, for the commit/difftest hook.
// PARAMETERS
//  ADDR_WIDTH  5   GPR index width; must match RegisterFile ADDR_WIDTH
//  DATA_WIDTH  32  datapath width; only 32 is supported (lane logic is RV32)
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           asynchronous reset, active-high
//  in_valid       in   1           EXU has a result/load to retire
//  in_ready       out  1           WBU can accept this cycle
//  in_rd          in   ADDR_WIDTH  destination register
//  in_alu_result  in   DATA_WIDTH  result for non-load instructions
//  in_is_load     in   1           1 = wait for memory data instead of using in_alu_result
//  in_funct3      in   3           load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  in_addr_lo     in   2           load address bits [1:0] (byte lane select)
//  mem_rvalid     in   1           load data valid (single-cycle pulse)
//  mem_rdata      in   DATA_WIDTH  aligned 32-bit word containing the load data
//  rf_wen         out  1           register-file write enable
//  rf_waddr       out  ADDR_WIDTH  register-file write address
//  rf_wdata       out  DATA_WIDTH  register-file write data
//  wb_done        out  1           one-cycle commit pulse (also fires for rd==0)
// BEHAVIOUR
//  - States: IDLE, WAIT_MEM, WRITE. All outputs are driven from registers or from the state only.
//  - Reset (async, any state): state=IDLE; rd_q, data_q, funct3_q, lo_q = 0.
//    Outputs during reset: rf_wen=0, rf_waddr=0, rf_wdata=0, wb_done=0. in_ready=1 once state is IDLE.
//  - in_ready = (state != WAIT_MEM). A transfer fires when in_valid & in_ready at a rising edge.
//  - IDLE or WRITE state, transfer fires, load:
//      capture rd, funct3, addr_lo; next state = WAIT_MEM.
//  - IDLE or WRITE state, transfer fires, non-load:
//      capture rd and alu_result; next state = WRITE (back-to-back WRITE->WRITE allowed).
//  - WRITE state, no transfer: next state = IDLE.
//  - WAIT_MEM: in_valid is ignored. mem_rvalid=1 -> data_q = extend(mem_rdata); next state = WRITE.
//    No timeout: stays in WAIT_MEM until mem_rvalid.
//  - extend():
//      LB/LBU: byte mem_rdata[8*lo+7 : 8*lo], sign-/zero-extended.
//      LH/LHU: half selected by lo[1]; lo[0] is ignored.
//      LW and undefined funct3 (011/110/111): full word, lo ignored.
//  - In state WRITE:
//      rf_waddr = rd_q, rf_wdata = data_q, wb_done = 1.
//      rf_wen = (rd_q != 0), so x0 is never written but the commit is still reported.
//  - Outside WRITE: rf_wen = 0 and wb_done = 0. rf_waddr/rf_wdata hold their last values
//    (don't-care when rf_wen=0).
//  - Latency, accept edge -> rf_wen high:
//      non-load: 1 cycle.
//      load: 1 cycle after the mem_rvalid edge.
//  - mem_rvalid in IDLE/WRITE: ignored; no state or data change.
//  - mem_rvalid together with rst: reset wins; the data is dropped.
//  - At most one outstanding load; the memory side never sees a second request while in WAIT_MEM.
// TESTING
//  1. ALU op: rd=5, alu=0x1234_5678, accept -> next cycle rf_wen=1, waddr=5,
//     wdata=0x12345678, wb_done=1; cycle after: IDLE.
//  2. LB: lo=3, mem_rdata=0x80FF_0011 -> wdata=0xFFFF_FF80.
//     LBU same inputs -> 0x0000_0080. LH lo=2 -> 0xFFFF_80FF.
//  3. rd=0, alu=0xDEAD_BEEF -> wb_done=1, rf_wen=0.
//  4. Back-to-back ALU ops rd=1,2,3 with in_valid held high -> three consecutive rf_wen cycles,
//     in_ready held 1.
//  5. Load accepted, hold mem_rvalid=0 for 10 cycles -> in_ready=0 throughout, no rf_wen;
//     assert rst mid-wait -> IDLE, outputs 0, in_ready=1; a late mem_rvalid causes no write.
//  6. mem_rvalid pulse while IDLE with mem_rdata=0xFFFF_FFFF -> no rf_wen, no wb_done,
//     state stays IDLE.

Source files
------------

// File: rtl/ysyx_24100005_wbu.sv
// Writeback unit: retires ALU results and loads into the GPR file, one commit per instruction.
// Loads park in WAIT_MEM until mem_rvalid, then the selected lane is extended and written.
module ysyx_24100005_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            funct3_q;
  logic [1:0]            lo_q;
  logic                  fire;
  logic [DATA_WIDTH-1:0] ld_data;

  function automatic logic [DATA_WIDTH-1:0] extend(
    input logic [2:0]            f3,
    input logic [1:0]            lo,
    input logic [DATA_WIDTH-1:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  return {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  return {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  return {{(DATA_WIDTH-16){1'b0}}, h};
      default: return w;  // LW and the undefined encodings take the whole word
    endcase
  endfunction

  assign fire    = in_valid & in_ready;
  assign ld_data = extend(funct3_q, lo_q, mem_rdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_q     <= '0;
      waddr_q  <= '0;
      data_q   <= '0;
      funct3_q <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE, WRITE: begin
          if (fire) begin
            rd_q <= in_rd;
            if (in_is_load) begin
              funct3_q <= in_funct3;
              lo_q     <= in_addr_lo;
              state    <= WAIT_MEM;
            end else begin
              waddr_q <= in_rd;
              data_q  <= in_alu_result;
              state   <= WRITE;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_MEM: begin
          // waddr_q/data_q only move on entry to WRITE so the RF port holds steady otherwise
          if (mem_rvalid) begin
            waddr_q <= rd_q;
            data_q  <= ld_data;
            state   <= WRITE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state != WAIT_MEM);
  assign wb_done  = (state == WRITE);
  assign rf_wen   = (state == WRITE) && (waddr_q != '0);
  assign rf_waddr = waddr_q;
  assign rf_wdata = data_q;

endmodule

// File: tb/tb_ysyx_24100005_wbu.sv
// Bench for the writeback unit: vector table through a commit scoreboard, plus
// hand-written sequences for back-to-back, stalled-load/reset and stray mem_rvalid cases.
module tb_ysyx_24100005_wbu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_done;

  ysyx_24100005_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_alu_result(in_alu_result), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_done(wb_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic [31:0] src;   // alu result, or memory word for loads
    logic [31:0] exp;
    logic        wen;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: observe commits at the falling edge, then return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (wb_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_commit: got waddr=%0d wdata=0x%08h wen=%0b expected no commit at %0t",
                   rf_waddr, rf_wdata, rf_wen, $time);
        end else begin
          e = sb.pop_front();
          chk("commit_waddr", {27'd0, rf_waddr}, {27'd0, e.rd});
          chk("commit_wdata", rf_wdata, e.data);
          chk("commit_wen", {31'd0, rf_wen}, {31'd0, e.wen});
        end
      end else if (rf_wen) begin
        checks++;
        errors++;
        $display("FAIL wen_without_done: got rf_wen=1 expected 0 at %0t", $time);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic drive_req(input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [4:0] rd, input logic [31:0] alu);
    in_valid      = 1'b1;
    in_is_load    = ld;
    in_funct3     = f3;
    in_addr_lo    = lo;
    in_rd         = rd;
    in_alu_result = alu;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    drive_req(v.ld, v.f3, v.lo, v.rd, v.ld ? 32'h5A5A_5A5A : v.src);
    e.rd = v.rd; e.data = v.exp; e.wen = v.wen;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    if (v.ld) begin
      chk("load_wait_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("load_still_wait", {31'd0, in_ready}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = v.src;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    chk("latency_done", {31'd0, wb_done}, 32'd1);
    tick();
    chk("back_idle_done", {31'd0, wb_done}, 32'd0);
    chk("back_idle_ready", {31'd0, in_ready}, 32'd1);
  endtask

  function automatic vec_t mk(input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                              input logic [4:0] rd, input logic [31:0] src,
                              input logic [31:0] exp, input logic wen);
    vec_t v;
    v.ld = ld; v.f3 = f3; v.lo = lo; v.rd = rd; v.src = src; v.exp = exp; v.wen = wen;
    return v;
  endfunction

  initial begin
    exp_t e;
    vecs.push_back(mk(1'b0, 3'b000, 2'd0, 5'd5,  32'h1234_5678, 32'h1234_5678, 1'b1));
    vecs.push_back(mk(1'b1, 3'b000, 2'd3, 5'd6,  32'h80FF_0011, 32'hFFFF_FF80, 1'b1));
    vecs.push_back(mk(1'b1, 3'b100, 2'd3, 5'd7,  32'h80FF_0011, 32'h0000_0080, 1'b1));
    vecs.push_back(mk(1'b1, 3'b001, 2'd2, 5'd8,  32'h80FF_0011, 32'hFFFF_80FF, 1'b1));
    vecs.push_back(mk(1'b1, 3'b101, 2'd2, 5'd9,  32'h80FF_0011, 32'h0000_80FF, 1'b1));
    vecs.push_back(mk(1'b1, 3'b001, 2'd3, 5'd10, 32'h80FF_0011, 32'hFFFF_80FF, 1'b1));
    vecs.push_back(mk(1'b1, 3'b000, 2'd0, 5'd11, 32'h80FF_0011, 32'h0000_0011, 1'b1));
    vecs.push_back(mk(1'b1, 3'b000, 2'd2, 5'd12, 32'h80FF_0011, 32'hFFFF_FFFF, 1'b1));
    vecs.push_back(mk(1'b1, 3'b100, 2'd1, 5'd13, 32'h80FF_A311, 32'h0000_00A3, 1'b1));
    vecs.push_back(mk(1'b1, 3'b001, 2'd1, 5'd14, 32'h1234_8001, 32'hFFFF_8001, 1'b1));
    vecs.push_back(mk(1'b1, 3'b101, 2'd0, 5'd15, 32'h1234_8001, 32'h0000_8001, 1'b1));
    vecs.push_back(mk(1'b1, 3'b010, 2'd1, 5'd16, 32'h80FF_0011, 32'h80FF_0011, 1'b1));
    vecs.push_back(mk(1'b1, 3'b011, 2'd3, 5'd17, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1));
    vecs.push_back(mk(1'b1, 3'b110, 2'd2, 5'd18, 32'h8765_4321, 32'h8765_4321, 1'b1));
    vecs.push_back(mk(1'b1, 3'b111, 2'd1, 5'd31, 32'h0000_FF80, 32'h0000_FF80, 1'b1));
    vecs.push_back(mk(1'b0, 3'b000, 2'd0, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(1'b1, 3'b000, 2'd3, 5'd0,  32'h80FF_0011, 32'hFFFF_FF80, 1'b0));

    rst = 1'b1;
    in_valid = 1'b0; in_rd = '0; in_alu_result = '0; in_is_load = 1'b0;
    in_funct3 = '0; in_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_done", {31'd0, wb_done}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) apply(vecs[i]);
    drain("table_drain");

    // back-to-back ALU ops keep WRITE busy every cycle
    for (int k = 1; k <= 3; k++) begin
      drive_req(1'b0, 3'b000, 2'd0, 5'(k), 32'h1000_0000 + k);
      e.rd = 5'(k); e.data = 32'h1000_0000 + k; e.wen = 1'b1;
      sb.push_back(e);
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("b2b_wen", {31'd0, rf_wen}, 32'd1);
    end
    in_valid = 1'b0;
    drain("b2b_drain");
    chk("b2b_idle", {31'd0, wb_done}, 32'd0);

    // load with in_valid held during the wait: the extra request must not be taken
    drive_req(1'b1, 3'b010, 2'd0, 5'd20, 32'h0);
    e.rd = 5'd20; e.data = 32'h0BAD_F00D; e.wen = 1'b1;
    sb.push_back(e);
    tick();
    drive_req(1'b0, 3'b000, 2'd0, 5'd21, 32'h1111_1111);
    for (int k = 0; k < 3; k++) begin
      chk("ignore_valid_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_rvalid = 1'b0;
    tick();
    drain("ignore_valid_drain");

    // stalled load, reset in the middle of the wait, then a late mem_rvalid
    drive_req(1'b1, 3'b000, 2'd1, 5'd22, 32'h0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_wen", {31'd0, rf_wen}, 32'd0);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_wen", {31'd0, rf_wen}, 32'd0);
    chk("midrst_done", {31'd0, wb_done}, 32'd0);
    chk("midrst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("midrst_wdata", rf_wdata, 32'd0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("late_rvalid_wen", {31'd0, rf_wen}, 32'd0);
    chk("late_rvalid_done", {31'd0, wb_done}, 32'd0);
    tick();

    // mem_rvalid coinciding with reset is dropped
    drive_req(1'b1, 3'b010, 2'd0, 5'd23, 32'h0);
    tick();
    in_valid = 1'b0;
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
    tick();
    rst = 1'b0; mem_rvalid = 1'b0;
    tick();
    chk("rst_rvalid_done", {31'd0, wb_done}, 32'd0);
    chk("rst_rvalid_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // stray mem_rvalid while IDLE
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("stray_wen", {31'd0, rf_wen}, 32'd0);
    chk("stray_done", {31'd0, wb_done}, 32'd0);
    chk("stray_ready", {31'd0, in_ready}, 32'd1);
    tick();
    apply(mk(1'b0, 3'b000, 2'd0, 5'd4, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b1));
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
